// File: rtl/scff_chain.sv
// WIDTH-bit scan/config chain with shift-progress counter and flags.
// Optional registered parity output par when SCFF_CHAIN_PARITY_EN is defined.
module scff_chain #(
  parameter int               WIDTH     = 16,
  parameter int               MODE      = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              CW        = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preset,
  input  logic             shift_en,
  input  logic             load_en,
  input  logic             DI,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SO,
  output logic [CW-1:0]    cnt,
  output logic             full,
`ifdef SCFF_CHAIN_PARITY_EN
  output logic             par,
`endif
  output logic             ovf
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILL,
    ST_FULL
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             ovf_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] shifted;
  logic             aclk;

  // Every register in the block runs off this one selected edge.
  if (MODE != 0) begin : g_pos
    assign aclk = clk;
  end else begin : g_neg
    assign aclk = ~clk;
  end

  if (WIDTH == 1) begin : g_w1
    assign shifted = DI;
  end else begin : g_wn
    assign shifted = {Q[WIDTH-2:0], DI};
  end

  assign SO   = Q[WIDTH-1];
  assign full = (cnt == CW'(WIDTH));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    q_nxt     = Q;
    priority case (1'b1)
      shift_en: begin
        q_nxt = shifted;
        unique case (state)
          ST_EMPTY: begin
            cnt_nxt   = CW'(1);
            state_nxt = (WIDTH == 1) ? ST_FULL : ST_FILL;
          end
          ST_FILL: begin
            cnt_nxt = cnt + CW'(1);
            if (cnt_nxt == CW'(WIDTH))
              state_nxt = ST_FULL;
          end
          ST_FULL: ovf_nxt = 1'b1;
          default: state_nxt = ST_EMPTY;
        endcase
      end
      load_en: begin
        q_nxt     = D;
        cnt_nxt   = '0;
        ovf_nxt   = 1'b0;
        state_nxt = ST_EMPTY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge aclk or negedge reset or negedge preset) begin
    if (!reset) begin
      Q <= RESET_VAL;
    end else if (!preset) begin
      Q <= '1;
    end else begin
      Q <= q_nxt;
    end
  end

  // Preset only touches the data; progress tracking holds while it is low.
  always_ff @(posedge aclk or negedge reset) begin
    if (!reset) begin
      state <= ST_EMPTY;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (preset) begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
    end
  end

`ifdef SCFF_CHAIN_PARITY_EN
  always_ff @(posedge aclk or negedge reset or negedge preset) begin
    if (!reset) begin
      par <= ^RESET_VAL;
    end else if (!preset) begin
      par <= 1'(WIDTH % 2);
    end else begin
      par <= ^q_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_scff_chain.sv
// Random + directed bench for scff_chain: rising/falling 8-bit chains
// and a 1-bit chain, all checked against an arithmetic reference model.
module tb_scff_chain;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       preset = 1'b1;
  logic       shift_en = 1'b0;
  logic       load_en = 1'b0;
  logic       di = 1'b0;
  logic [7:0] din = '0;

  logic [7:0] q_p, q_n;
  logic [0:0] q_1;
  logic [3:0] cnt_p, cnt_n;
  logic [0:0] cnt_1;
  logic       so_p, so_n, so_1;
  logic       full_p, full_n, full_1;
  logic       ovf_p, ovf_n, ovf_1;
`ifdef SCFF_CHAIN_PARITY_EN
  logic       par_p, par_n, par_1;
`endif

  int n_chk = 0;
  int n_err = 0;

  int         W  [3] = '{8, 8, 1};
  logic [7:0] RV [3] = '{8'hA5, 8'h3C, 8'h01};
  logic [7:0] mq [3];
  int         mc [3];
  bit         mo [3];

  always #5 clk = ~clk;

  scff_chain #(.WIDTH(8), .MODE(1), .RESET_VAL(8'hA5)) u_p (
    .clk(clk), .reset(reset), .preset(preset),
    .shift_en(shift_en), .load_en(load_en),
    .DI(di), .D(din), .Q(q_p), .SO(so_p),
    .cnt(cnt_p), .full(full_p),
`ifdef SCFF_CHAIN_PARITY_EN
    .par(par_p),
`endif
    .ovf(ovf_p)
  );

  scff_chain #(.WIDTH(8), .MODE(0), .RESET_VAL(8'h3C)) u_n (
    .clk(clk), .reset(reset), .preset(preset),
    .shift_en(shift_en), .load_en(load_en),
    .DI(di), .D(din), .Q(q_n), .SO(so_n),
    .cnt(cnt_n), .full(full_n),
`ifdef SCFF_CHAIN_PARITY_EN
    .par(par_n),
`endif
    .ovf(ovf_n)
  );

  scff_chain #(.WIDTH(1), .MODE(1), .RESET_VAL(1'b1)) u_1 (
    .clk(clk), .reset(reset), .preset(preset),
    .shift_en(shift_en), .load_en(load_en),
    .DI(di), .D(din[0:0]), .Q(q_1), .SO(so_1),
    .cnt(cnt_1), .full(full_1),
`ifdef SCFF_CHAIN_PARITY_EN
    .par(par_1),
`endif
    .ovf(ovf_1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] msk(input int i);
    return 8'((1 << W[i]) - 1);
  endfunction

  task automatic async_apply(input int i);
    if (!reset) begin
      mq[i] = RV[i] & msk(i);
      mc[i] = 0;
      mo[i] = 1'b0;
    end else if (!preset) begin
      mq[i] = msk(i);
    end
  endtask

  task automatic edge_apply(input int i);
    if (reset && preset) begin
      if (shift_en) begin
        if (mc[i] == W[i]) mo[i] = 1'b1;
        else mc[i]++;
        mq[i] = ((mq[i] << 1) | {7'd0, di}) & msk(i);
      end else if (load_en) begin
        mq[i] = din & msk(i);
        mc[i] = 0;
        mo[i] = 1'b0;
      end
    end
  endtask

  task automatic chk_i(input int i, input string t,
                       input logic [7:0] q, input int c,
                       input logic f, input logic o,
                       input logic so, input logic pr);
    chk({t, ".q"},    32'(q),  32'(mq[i]));
    chk({t, ".cnt"},  32'(c),  32'(mc[i]));
    chk({t, ".full"}, 32'(f),  32'(mc[i] == W[i]));
    chk({t, ".ovf"},  32'(o),  32'(mo[i]));
    chk({t, ".so"},   32'(so), 32'(mq[i][W[i]-1]));
`ifdef SCFF_CHAIN_PARITY_EN
    chk({t, ".par"},  32'(pr), 32'($countones(mq[i]) % 2));
`else
    if (pr !== 1'b0) $display("note: parity unexpectedly driven");
`endif
  endtask

  task automatic chk_p(input string t);
`ifdef SCFF_CHAIN_PARITY_EN
    chk_i(0, {t, "/p"}, q_p, int'(cnt_p), full_p, ovf_p, so_p, par_p);
`else
    chk_i(0, {t, "/p"}, q_p, int'(cnt_p), full_p, ovf_p, so_p, 1'b0);
`endif
  endtask

  task automatic chk_n(input string t);
`ifdef SCFF_CHAIN_PARITY_EN
    chk_i(1, {t, "/n"}, q_n, int'(cnt_n), full_n, ovf_n, so_n, par_n);
`else
    chk_i(1, {t, "/n"}, q_n, int'(cnt_n), full_n, ovf_n, so_n, 1'b0);
`endif
  endtask

  task automatic chk_1(input string t);
`ifdef SCFF_CHAIN_PARITY_EN
    chk_i(2, {t, "/1"}, {7'd0, q_1}, int'(cnt_1), full_1, ovf_1,
          so_1, par_1);
`else
    chk_i(2, {t, "/1"}, {7'd0, q_1}, int'(cnt_1), full_1, ovf_1,
          so_1, 1'b0);
`endif
  endtask

  // Drive one vector mid-cycle; rising chains take the posedge,
  // the falling chain takes the negedge that follows it.
  task automatic vec(input logic r, input logic p, input logic s,
                     input logic l, input logic d,
                     input logic [7:0] dv);
    reset    = r;
    preset   = p;
    shift_en = s;
    load_en  = l;
    di       = d;
    din      = dv;
    for (int i = 0; i < 3; i++) async_apply(i);
    #1;
    chk_p("async");
    chk_n("async");
    chk_1("async");
    @(posedge clk);
    #1;
    edge_apply(0);
    edge_apply(2);
    chk_p("pos");
    chk_n("pos");
    chk_1("pos");
    @(negedge clk);
    #1;
    edge_apply(1);
    chk_n("neg");
    #1;
  endtask

  initial begin
    logic [7:0] bits;
    bits = 8'b1011_0010;
    @(negedge clk);
    #2;
    // reset, preset and their interaction
    vec(0, 1, 0, 0, 0, 8'h00);
    chk("t1_rst_q", 32'(q_p), 32'h A5);
    vec(1, 1, 1, 0, 1, 8'h00);
    vec(1, 1, 1, 0, 0, 8'h00);
    vec(1, 0, 1, 0, 0, 8'h00);
    chk("t1_pre_q", 32'(q_p), 32'h FF);
    chk("t1_pre_cnt", 32'(cnt_p), 32'd2);
    vec(0, 0, 0, 0, 0, 8'h00);
    chk("t1_both_q", 32'(q_p), 32'h A5);
    // full shift of a known pattern
    for (int k = 7; k >= 0; k--) vec(1, 1, 1, 0, bits[k], 8'h00);
    chk("t2_q", 32'(q_p), 32'h B2);
    chk("t2_full", 32'(full_p), 32'd1);
    chk("t2_so", 32'(so_p), 32'd1);
    // overflow then clear by load
    vec(1, 1, 1, 0, 1, 8'h00);
    chk("t3_q", 32'(q_p), 32'h 65);
    chk("t3_ovf", 32'(ovf_p), 32'd1);
    vec(1, 1, 0, 1, 0, 8'h3C);
    chk("t3_ld_q", 32'(q_p), 32'h 3C);
    // shift wins over load
    vec(1, 1, 0, 1, 0, 8'h81);
    vec(1, 1, 1, 1, 0, 8'hFF);
    chk("t4_q", 32'(q_p), 32'h 02);
    chk("t4_cnt", 32'(cnt_p), 32'd1);
    // falling-edge load, reset mid-sequence
    vec(1, 1, 0, 1, 0, 8'h5A);
    chk("t5_q_n", 32'(q_n), 32'h 5A);
    vec(1, 1, 1, 0, 1, 8'h00);
    vec(1, 1, 1, 0, 1, 8'h00);
    vec(1, 1, 1, 0, 1, 8'h00);
    vec(0, 1, 1, 0, 1, 8'h00);
    chk("t5_cnt_n", 32'(cnt_n), 32'd0);
    // parity on the 8-bit chain, overflow on the 1-bit chain
    vec(1, 1, 0, 1, 0, 8'h07);
`ifdef SCFF_CHAIN_PARITY_EN
    chk("t6_par_ld", 32'(par_p), 32'd1);
`endif
    vec(1, 0, 0, 0, 0, 8'h00);
`ifdef SCFF_CHAIN_PARITY_EN
    chk("t6_par_pre", 32'(par_p), 32'd0);
`endif
    vec(0, 1, 0, 0, 0, 8'h00);
    vec(1, 1, 1, 0, 1, 8'h00);
    chk("t6_full_1", 32'(full_1), 32'd1);
    vec(1, 1, 1, 0, 0, 8'h00);
    chk("t6_q_1", 32'(q_1), 32'd0);
    chk("t6_ovf_1", 32'(ovf_1), 32'd1);
    // random traffic
    for (int k = 0; k < 400; k++) begin
      vec(($urandom % 40) != 0, ($urandom % 20) != 0,
          ($urandom % 3) != 0, ($urandom % 2) != 0,
          1'($urandom), 8'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
